// File: rtl/c_phase_ctrl.sv
// Phase sequencer for the SAT core clock driver.
// Walks SRAM load, VAR init and rotating PROC rounds, then reports.
module c_phase_ctrl #(
  parameter int NUM_VPE = 12,
  parameter int LEN_W   = 8,
  parameter int RND_W   = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic             ABORT,
  input  logic [LEN_W-1:0] SRAM_LEN,
  input  logic [LEN_W-1:0] VAR_LEN,
  input  logic [RND_W-1:0] MAX_ROUNDS,
  input  logic             SHF_EN,
  input  logic             SAT_FOUND,
  output logic             SRAM_STATE,
  output logic             VAR_STATE,
  output logic             PROC_STATE,
  output logic             SHUFFLE,
  output logic             BUSY,
  output logic             DONE,
  output logic             SAT_OUT,
  output logic [RND_W-1:0] ROUND_CNT,
  output logic [3:0]       STEP_CNT
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SRAM = 3'd1;
  localparam logic [2:0] S_VAR  = 3'd2;
  localparam logic [2:0] S_PROC = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  localparam logic [3:0] LAST_STEP = 4'(NUM_VPE - 1);

  logic [2:0]       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] var_len_q, var_len_d;
  logic [RND_W-1:0] max_q, max_d;
  logic             shf_en_q, shf_en_d;
  logic [3:0]       step_q, step_d;
  logic [RND_W-1:0] round_q, round_d;
  logic             shuffle_q, shuffle_d;
  logic             sat_q, sat_d;
  logic             wrap;

  assign wrap = (step_q == LAST_STEP);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    var_len_d = var_len_q;
    max_d     = max_q;
    shf_en_d  = shf_en_q;
    step_d    = step_q;
    round_d   = round_q;
    shuffle_d = shuffle_q;
    sat_d     = sat_q;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          var_len_d = VAR_LEN;
          max_d     = MAX_ROUNDS;
          shf_en_d  = SHF_EN;
          sat_d     = 1'b0;
          round_d   = '0;
          step_d    = '0;
          shuffle_d = 1'b0;
          if (SRAM_LEN != '0) begin
            state_d = S_SRAM;
            cnt_d   = SRAM_LEN;
          end else if (VAR_LEN != '0) begin
            state_d = S_VAR;
            cnt_d   = VAR_LEN;
          end else begin
            state_d = S_PROC;
          end
        end
      end
      S_SRAM: begin
        if (cnt_q == LEN_W'(1)) begin
          if (var_len_q != '0) begin
            state_d = S_VAR;
            cnt_d   = var_len_q;
          end else begin
            state_d = S_PROC;
          end
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      S_VAR: begin
        if (cnt_q == LEN_W'(1)) begin
          state_d = S_PROC;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      S_PROC: begin
        if (wrap) begin
          step_d  = '0;
          round_d = (&round_q) ? round_q : round_q + RND_W'(1);
          if (shf_en_q) begin
            shuffle_d = ~shuffle_q;
          end
        end else begin
          step_d = step_q + 4'd1;
        end
        // SAT takes priority over a budget hit on the same edge
        if (SAT_FOUND) begin
          state_d = S_FIN;
          sat_d   = 1'b1;
        end else if (wrap && max_q != '0 && round_d == max_q) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (ABORT && state_q != S_IDLE) begin
      state_d = S_IDLE;
      sat_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      var_len_q <= '0;
      max_q     <= '0;
      shf_en_q  <= 1'b0;
      step_q    <= '0;
      round_q   <= '0;
      shuffle_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      var_len_q <= var_len_d;
      max_q     <= max_d;
      shf_en_q  <= shf_en_d;
      step_q    <= step_d;
      round_q   <= round_d;
      shuffle_q <= shuffle_d;
      sat_q     <= sat_d;
    end
  end

  assign SRAM_STATE = (state_q == S_SRAM);
  assign VAR_STATE  = (state_q == S_VAR);
  assign PROC_STATE = (state_q == S_PROC);
  assign DONE       = (state_q == S_FIN);
  assign BUSY       = (state_q != S_IDLE);
  assign SHUFFLE    = shuffle_q;
  assign SAT_OUT    = sat_q;
  assign ROUND_CNT  = round_q;
  assign STEP_CNT   = step_q;

endmodule

// File: tb/tb_c_phase_ctrl.sv
// Randomized bench for c_phase_ctrl against a per-run trace model.
// Expected outputs are derived arithmetically from cycle index.
module tb_c_phase_ctrl;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        START = 1'b0;
  logic        ABORT = 1'b0;
  logic [7:0]  SRAM_LEN = '0;
  logic [7:0]  VAR_LEN = '0;
  logic [15:0] MAX_ROUNDS = '0;
  logic        SHF_EN = 1'b0;
  logic        SAT_FOUND = 1'b0;
  logic        SRAM_STATE, VAR_STATE, PROC_STATE, SHUFFLE;
  logic        BUSY, DONE, SAT_OUT;
  logic [15:0] ROUND_CNT;
  logic [3:0]  STEP_CNT;

  int checks = 0;
  int errors = 0;

  c_phase_ctrl dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .ABORT(ABORT),
    .SRAM_LEN(SRAM_LEN), .VAR_LEN(VAR_LEN),
    .MAX_ROUNDS(MAX_ROUNDS), .SHF_EN(SHF_EN),
    .SAT_FOUND(SAT_FOUND), .SRAM_STATE(SRAM_STATE),
    .VAR_STATE(VAR_STATE), .PROC_STATE(PROC_STATE),
    .SHUFFLE(SHUFFLE), .BUSY(BUSY), .DONE(DONE),
    .SAT_OUT(SAT_OUT), .ROUND_CNT(ROUND_CNT),
    .STEP_CNT(STEP_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] all_out();
    return {9'd0, SRAM_STATE, VAR_STATE, PROC_STATE, SHUFFLE,
            BUSY, DONE, SAT_OUT, ROUND_CNT, STEP_CNT} >> 0;
  endfunction

  // a_sel < 0: no abort; else abort cycle = 1 + a_sel % (total+1)
  task automatic run(input int s, input int v, input int m,
                     input bit shf, input int k, input int a_sel,
                     input bit st_proc, input string nm);
    int p, total, a, last, j, rf, sf;
    bit satf, shff, in_proc;
    bit e_sr, e_vr, e_pr, e_bs, e_dn, e_st, e_sh;
    int e_rn, e_sp;
    if (k >= 0 && (m == 0 || k < 12 * m)) begin
      p = k + 1;
      satf = 1'b1;
    end else begin
      p = 12 * m;
      satf = 1'b0;
    end
    total = s + v + p;
    rf = p / 12;
    sf = p % 12;
    shff = shf && (rf % 2 == 1);
    a = (a_sel < 0) ? -1 : 1 + a_sel % (total + 1);
    last = (a > 0) ? a + 1 : total + 2;
    @(negedge CLK);
    SRAM_LEN = 8'(s);
    VAR_LEN = 8'(v);
    MAX_ROUNDS = 16'(m);
    SHF_EN = shf;
    START = 1'b1;
    ABORT = 1'($urandom_range(0, 1));
    SAT_FOUND = 1'b0;
    for (int c = 1; c <= last; c++) begin
      @(negedge CLK);
      START = 1'b0;
      SRAM_LEN = 8'($urandom);
      VAR_LEN = 8'($urandom);
      MAX_ROUNDS = 16'($urandom);
      SHF_EN = 1'($urandom);
      {e_sr, e_vr, e_pr, e_dn, e_st, e_sh} = '0;
      e_bs = 1'b1;
      e_rn = 0;
      e_sp = 0;
      in_proc = 1'b0;
      j = 0;
      if (a > 0 && c == a + 1) begin
        chk({nm, ".abort_phase"},
            {SRAM_STATE, VAR_STATE, PROC_STATE, BUSY, DONE, SAT_OUT},
            6'b0);
      end else begin
        if (c <= s) begin
          e_sr = 1'b1;
        end else if (c <= s + v) begin
          e_vr = 1'b1;
        end else if (c <= total) begin
          e_pr = 1'b1;
          in_proc = 1'b1;
          j = c - s - v - 1;
          e_rn = j / 12;
          e_sp = j % 12;
          e_sh = shf && ((j / 12) % 2 == 1);
        end else begin
          e_rn = rf;
          e_sp = sf;
          e_sh = shff;
          e_st = satf;
          if (c == total + 1) e_dn = 1'b1;
          else e_bs = 1'b0;
        end
        chk({nm, ".phase"},
            {SRAM_STATE, VAR_STATE, PROC_STATE, BUSY, DONE, SAT_OUT},
            {e_sr, e_vr, e_pr, e_bs, e_dn, e_st});
        chk({nm, ".round"}, ROUND_CNT, e_rn);
        chk({nm, ".step"}, STEP_CNT, e_sp);
        chk({nm, ".shuffle"}, SHUFFLE, e_sh);
      end
      ABORT = (c == a);
      SAT_FOUND = in_proc ? (j == k) : 1'($urandom);
      if (st_proc && in_proc && j == 3) START = 1'b1;
    end
    ABORT = 1'b0;
    SAT_FOUND = 1'b0;
    START = 1'b0;
  endtask

  initial begin
    int s, v, m, k, a;
    #1;
    chk("reset_outputs", all_out(), 0);
    #12 RESET_N = 1'b1;
    run(3, 2, 2, 1'b0, -1, -1, 1'b0, "nominal");
    run(1, 1, 0, 1'b1, 3 * 12 + 5, -1, 1'b0, "sat_exit");
    run(0, 0, 1, 1'b0, -1, -1, 1'b0, "zero_len");
    run(2, 2, 1, 1'b0, 11, -1, 1'b0, "sat_on_wrap");
    run(2, 2, 1, 1'b0, 11, 15, 1'b0, "abort_on_wrap");
    run(3, 2, 2, 1'b0, -1, 3, 1'b0, "abort_var");
    run(1, 1, 2, 1'b1, -1, -1, 1'b1, "start_in_proc");
    // async reset between edges while in PROC
    @(negedge CLK);
    SRAM_LEN = 8'd1;
    VAR_LEN = 8'd1;
    MAX_ROUNDS = 16'd0;
    SHF_EN = 1'b1;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (18) @(negedge CLK);
    chk("pre_reset_proc", PROC_STATE, 1'b1);
    #2 RESET_N = 1'b0;
    #1 chk("async_reset", all_out(), 0);
    @(negedge CLK);
    chk("reset_hold", all_out(), 0);
    RESET_N = 1'b1;
    run(3, 2, 2, 1'b0, -1, -1, 1'b0, "post_reset");
    for (int r = 0; r < 40; r++) begin
      s = $urandom_range(0, 4);
      v = $urandom_range(0, 4);
      m = $urandom_range(0, 3);
      if (m == 0 || $urandom_range(0, 1) == 1)
        k = $urandom_range(0, 12 * ((m == 0) ? 3 : m) + 3);
      else
        k = -1;
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 200) : -1;
      run(s, v, m, 1'($urandom), k, a, 1'($urandom), "rand");
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
